// File: rtl/regfile_operand_ctrl.sv
// regfile_operand_ctrl
// Operand-fetch sequencer for a 32x32 register file with a 1-cycle registered
// read (two read ports, one write port). It accepts a decode request, issues
// the reads, forwards writes that race the read so operands are never stale,
// and presents the operands to execute on a valid/ready handshake. The single
// write port is shared between execute write-back (priority) and a debug
// writer. With ZERO_X0 set, x0 reads as zero and writes to x0 are dropped.
module regfile_operand_ctrl #(
  parameter int TAG_W   = 8,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  // decode request
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic             req_use_rs1,
  input  logic             req_use_rs2,
  input  logic [TAG_W-1:0] req_tag,
  // write-back requester (highest priority)
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  // debug write requester
  input  logic             dbg_wr_valid,
  input  logic [4:0]       dbg_wr_addr,
  input  logic [31:0]      dbg_wr_data,
  output logic             dbg_wr_ready,
  // register file write port
  output logic             rf_wr_en,
  output logic [4:0]       rf_wr_addr,
  output logic [31:0]      rf_wr_data,
  // register file read ports
  output logic             rf_rd_en1,
  output logic             rf_rd_en2,
  output logic [4:0]       rf_rd_addr1,
  output logic [4:0]       rf_rd_addr2,
  input  logic [31:0]      rf_rd_data1,
  input  logic [31:0]      rf_rd_data2,
  // operands to execute
  output logic             op_valid,
  input  logic             op_ready,
  output logic [31:0]      op_rs1_data,
  output logic [31:0]      op_rs2_data,
  output logic [TAG_W-1:0] op_tag
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_OUT
  } state_t;

  state_t state, state_next;

  // Effective write this cycle (after arbitration and x0 suppression)
  logic        wr_eff;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  // FSM strobes
  logic accept;
  logic handshake;

  // Request captured at accept time
  logic [4:0]       rs1_q, rs2_q;
  logic             use1_q, use2_q;
  logic [TAG_W-1:0] tag_q;

  // Writes that landed in the accept cycle and were missed by the read
  logic        fwd_v1, fwd_v2;
  logic [31:0] fwd_d1, fwd_d2;

  // Operand values chosen in READ, and OUT-phase refresh strobes
  logic [31:0] sel1, sel2;
  logic        upd1, upd2;

  // True when address a names the hard-wired zero register.
  function automatic logic is_x0(input logic [4:0] a);
    return ZERO_X0 && (a == 5'd0);
  endfunction

  // Write-port arbitration: write-back always wins, debug gets leftovers.
  always_comb begin
    dbg_wr_ready = dbg_wr_valid & ~wb_valid & ~reset;
    wr_addr      = wb_valid ? wb_addr : dbg_wr_addr;
    wr_data      = wb_valid ? wb_data : dbg_wr_data;
    // A granted debug write to x0 is acknowledged but never reaches the array.
    wr_eff       = (wb_valid | dbg_wr_ready) & ~reset & ~is_x0(wr_addr);
    rf_wr_en     = wr_eff;
    rf_wr_addr   = wr_addr;
    rf_wr_data   = wr_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic, request acceptance and operand handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (op_ready) begin
          handshake = 1'b1;
          req_ready = 1'b1;
          if (req_valid) begin
            accept     = 1'b1;
            state_next = ST_READ;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Nothing is accepted or handed over while reset is held.
    if (reset) begin
      req_ready = 1'b0;
      accept    = 1'b0;
      handshake = 1'b0;
    end
  end

  // Read-port drive: enables only in the accept cycle, never for x0.
  always_comb begin
    rf_rd_en1   = accept & req_use_rs1 & ~is_x0(req_rs1);
    rf_rd_en2   = accept & req_use_rs2 & ~is_x0(req_rs2);
    rf_rd_addr1 = req_rs1;
    rf_rd_addr2 = req_rs2;
  end

  // Capture the request and any write that races the read in the accept cycle.
  always_ff @(posedge clk) begin
    // NOTE: these holding registers are cleared on reset only so the design
    // starts from a known state; they are consumed only after an accept.
    if (reset) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
      tag_q  <= '0;
      fwd_v1 <= 1'b0;
      fwd_v2 <= 1'b0;
      fwd_d1 <= '0;
      fwd_d2 <= '0;
    end else if (accept) begin
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      use1_q <= req_use_rs1;
      use2_q <= req_use_rs2;
      tag_q  <= req_tag;
      // The array updates on the same edge the read samples it, so the read
      // returns the old value; remember the new one here instead.
      fwd_v1 <= wr_eff && (wr_addr == req_rs1);
      fwd_v2 <= wr_eff && (wr_addr == req_rs2);
      fwd_d1 <= wr_data;
      fwd_d2 <= wr_data;
    end
  end

  // Operand selection in READ: zero, then live write, then forward, then array.
  always_comb begin
    sel1 = rf_rd_data1;
    if (!use1_q || is_x0(rs1_q))          sel1 = '0;
    else if (wr_eff && (wr_addr == rs1_q)) sel1 = wr_data;
    else if (fwd_v1)                       sel1 = fwd_d1;

    sel2 = rf_rd_data2;
    if (!use2_q || is_x0(rs2_q))          sel2 = '0;
    else if (wr_eff && (wr_addr == rs2_q)) sel2 = wr_data;
    else if (fwd_v2)                       sel2 = fwd_d2;
  end

  // Writes that hit a held operand while execute is stalled.
  always_comb begin
    upd1 = wr_eff && use1_q && !is_x0(rs1_q) && (wr_addr == rs1_q);
    upd2 = wr_eff && use2_q && !is_x0(rs2_q) && (wr_addr == rs2_q);
  end

  // Operand output registers: load in READ, refresh and release in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid    <= 1'b0;
      op_rs1_data <= '0;
      op_rs2_data <= '0;
      op_tag      <= '0;
    end else begin
      case (state)
        ST_READ: begin
          op_valid    <= 1'b1;
          op_rs1_data <= sel1;
          op_rs2_data <= sel2;
          op_tag      <= tag_q;
        end
        ST_OUT: begin
          if (upd1) op_rs1_data <= wr_data;
          if (upd2) op_rs2_data <= wr_data;
          if (handshake) op_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_operand_ctrl.sv
// Bench for regfile_operand_ctrl: directed scenarios followed by a randomized
// phase, every cycle compared against a transaction-level reference model
// (architectural register array plus an outstanding-request record).
module tb_regfile_operand_ctrl;

  localparam int TAG_W   = 8;
  localparam bit ZERO_X0 = 1'b1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [4:0]       req_rs1, req_rs2;
  logic             req_use_rs1, req_use_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             dbg_wr_valid;
  logic [4:0]       dbg_wr_addr;
  logic [31:0]      dbg_wr_data;
  logic             dbg_wr_ready;
  logic             rf_wr_en;
  logic [4:0]       rf_wr_addr;
  logic [31:0]      rf_wr_data;
  logic             rf_rd_en1, rf_rd_en2;
  logic [4:0]       rf_rd_addr1, rf_rd_addr2;
  logic [31:0]      rf_rd_data1, rf_rd_data2;
  logic             op_valid, op_ready;
  logic [31:0]      op_rs1_data, op_rs2_data;
  logic [TAG_W-1:0] op_tag;

  regfile_operand_ctrl #(.TAG_W(TAG_W), .ZERO_X0(ZERO_X0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_use_rs1(req_use_rs1), .req_use_rs2(req_use_rs2), .req_tag(req_tag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_addr(dbg_wr_addr),
    .dbg_wr_data(dbg_wr_data), .dbg_wr_ready(dbg_wr_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data), .op_tag(op_tag)
  );

  always #5 clk = ~clk;

  // Register file: registered read returning the pre-edge array contents.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_rd_en1) rf_rd_data1 <= rf_mem[rf_rd_addr1];
    if (rf_rd_en2) rf_rd_data2 <= rf_mem[rf_rd_addr2];
    if (rf_wr_en)  rf_mem[rf_wr_addr] <= rf_wr_data;
  end

  // Reference model state
  logic [31:0]      arch [32];
  int               cyc;
  int               valid_from;
  bit               pending;
  logic [4:0]       p_rs1, p_rs2;
  bit               p_use1, p_use2;
  logic [TAG_W-1:0] p_tag;
  bit               last_acc;

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit hard0(input logic [4:0] a);
    return ZERO_X0 && (a == 5'd0);
  endfunction

  // One clock: check all outputs mid-cycle against the model, then advance.
  task automatic cycle();
    bit          exp_valid, hs, exp_rdy, acc, w_en, e1, e2;
    logic [4:0]  w_addr;
    logic [31:0] w_data, x1, x2;
    @(negedge clk);
    exp_valid = pending && (cyc >= valid_from);
    hs        = exp_valid && op_ready && !reset;
    exp_rdy   = !reset && (!pending || hs);
    acc       = req_valid && exp_rdy;
    w_addr    = wb_valid ? wb_addr : dbg_wr_addr;
    w_data    = wb_valid ? wb_data : dbg_wr_data;
    w_en      = (wb_valid || dbg_wr_valid) && !reset && !hard0(w_addr);
    e1        = acc && req_use_rs1 && !hard0(req_rs1);
    e2        = acc && req_use_rs2 && !hard0(req_rs2);

    check("dbg_wr_ready", 32'(dbg_wr_ready), 32'(dbg_wr_valid && !wb_valid && !reset));
    check("rf_wr_en", 32'(rf_wr_en), 32'(w_en));
    if (w_en) begin
      check("rf_wr_addr", 32'(rf_wr_addr), 32'(w_addr));
      check("rf_wr_data", rf_wr_data, w_data);
    end
    if (!reset) check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rf_rd_en1", 32'(rf_rd_en1), 32'(e1));
    check("rf_rd_en2", 32'(rf_rd_en2), 32'(e2));
    if (e1) check("rf_rd_addr1", 32'(rf_rd_addr1), 32'(req_rs1));
    if (e2) check("rf_rd_addr2", 32'(rf_rd_addr2), 32'(req_rs2));
    check("op_valid", 32'(op_valid), 32'(exp_valid));
    if (exp_valid) begin
      // Operands always reflect every write committed before this cycle.
      x1 = (p_use1 && !hard0(p_rs1)) ? arch[p_rs1] : 32'd0;
      x2 = (p_use2 && !hard0(p_rs2)) ? arch[p_rs2] : 32'd0;
      check("op_rs1_data", op_rs1_data, x1);
      check("op_rs2_data", op_rs2_data, x2);
      check("op_tag", 32'(op_tag), 32'(p_tag));
    end

    @(posedge clk);
    if (w_en) arch[w_addr] = w_data;
    if (reset) begin
      pending = 1'b0;
    end else if (acc) begin
      pending    = 1'b1;
      valid_from = cyc + 2;
      p_rs1      = req_rs1;
      p_rs2      = req_rs2;
      p_use1     = req_use_rs1;
      p_use2     = req_use_rs2;
      p_tag      = req_tag;
    end else if (hs) begin
      pending = 1'b0;
    end
    last_acc = acc;
    cyc++;
    #1;
  endtask

  task automatic set_req(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                         input bit u1, input bit u2, input logic [TAG_W-1:0] t);
    req_valid   = v;
    req_rs1     = r1;
    req_rs2     = r2;
    req_use_rs1 = u1;
    req_use_rs2 = u2;
    req_tag     = t;
  endtask

  task automatic set_wb(input bit v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  task automatic set_dbg(input bit v, input logic [4:0] a, input logic [31:0] d);
    dbg_wr_valid = v;
    dbg_wr_addr  = a;
    dbg_wr_data  = d;
  endtask

  initial begin
    int next_tag;
    n_cmp = 0; n_err = 0; cyc = 0; valid_from = 0;
    pending = 1'b0; last_acc = 1'b0;
    p_rs1 = '0; p_rs2 = '0; p_use1 = 1'b0; p_use2 = 1'b0; p_tag = '0;
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    reset = 1'b1;
    op_ready = 1'b0;
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    set_wb(1'b0, 5'd0, 32'd0);
    set_dbg(1'b0, 5'd0, 32'd0);

    // Reset state
    cycle();
    cycle();
    check("rst_op_rs1", op_rs1_data, 32'd0);
    check("rst_op_rs2", op_rs2_data, 32'd0);
    check("rst_op_tag", 32'(op_tag), 32'd0);
    reset = 1'b0;

    // Preload every register through the write port (x0 write must be dropped)
    for (int i = 0; i < 32; i++) begin
      set_wb(1'b1, 5'(i), $urandom);
      cycle();
    end
    set_wb(1'b0, 5'd0, 32'd0);

    // Debug write x5, then read rs1=5 / rs2=x0
    set_dbg(1'b1, 5'd5, 32'h1234);
    cycle();
    set_dbg(1'b0, 5'd0, 32'd0);
    set_req(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 8'h11);
    cycle();
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    cycle();
    check("t1_op_valid", 32'(op_valid), 32'd1);
    check("t1_rs1", op_rs1_data, 32'h1234);
    check("t1_rs2", op_rs2_data, 32'd0);
    cycle();
    op_ready = 1'b1;
    cycle();
    op_ready = 1'b0;

    // Write-back to x7 in the same cycle the read of x7 is accepted
    set_wb(1'b1, 5'd7, 32'h1);
    cycle();
    set_wb(1'b1, 5'd7, 32'hA);
    set_req(1'b1, 5'd7, 5'd3, 1'b1, 1'b0, 8'h22);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    cycle();
    check("t2_rs1_fwd", op_rs1_data, 32'hA);
    op_ready = 1'b1;
    cycle();
    op_ready = 1'b0;

    // Write during READ, then another write while execute stalls in OUT
    set_req(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 8'h33);
    cycle();
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    set_wb(1'b1, 5'd7, 32'hB);
    cycle();
    check("t3_rs1_first", op_rs1_data, 32'hB);
    set_wb(1'b1, 5'd7, 32'hC);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    check("t3_rs1_upd", op_rs1_data, 32'hC);
    check("t3_tag_hold", 32'(op_tag), 32'h33);
    cycle();
    cycle();
    op_ready = 1'b1;
    cycle();
    op_ready = 1'b0;

    // Simultaneous write-back and debug write to different registers
    set_wb(1'b1, 5'd9, 32'h99);
    set_dbg(1'b1, 5'd10, 32'h1010);
    #1;
    check("t4_dbg_blocked", 32'(dbg_wr_ready), 32'd0);
    check("t4_wr_addr_wb", 32'(rf_wr_addr), 32'd9);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    cycle();
    set_dbg(1'b0, 5'd0, 32'd0);
    set_req(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 8'h44);
    cycle();
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    cycle();
    check("t4_rs1", op_rs1_data, 32'h99);
    check("t4_rs2", op_rs2_data, 32'h1010);
    op_ready = 1'b1;
    cycle();

    // Back-to-back requests with execute always ready (tags 1, 2, 3)
    next_tag = 1;
    for (int i = 0; i < 20 && next_tag < 4; i++) begin
      set_req(1'b1, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 1'b1, 1'b1, 8'(next_tag));
      cycle();
      if (last_acc) next_tag++;
    end
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    cycle();
    cycle();
    cycle();
    op_ready = 1'b0;

    // Reset while in READ drops the request
    set_req(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 8'h66);
    cycle();
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("t6_no_valid", 32'(op_valid), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    cycle();
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("t6_x0_wr_en", 32'(rf_wr_en), 32'd0);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_req($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      set_wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      set_dbg($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      op_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    reset = 1'b0;
    set_req(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    set_wb(1'b0, 5'd0, 32'd0);
    set_dbg(1'b0, 5'd0, 32'd0);
    op_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
